spi_txn_arbiter: RTL and testbench
==================================

// Module: spi_txn_arbiter
// PURPOSE
//  Shares one spi_master instance between NumRequesters clients. Round-robin arbitration, then a
//  full transaction over spi_master's register bus: load tx bytes, start, poll busy, read rx bytes.
//  Sits between client logic and spi_master's address/data/rd_wr port; sole master of that port.
// PARAMETERS
//  NumRequesters       4      number of clients (>=1); IdWidth = max(1,$clog2(NumRequesters))
//  BytesPerTransaction 1      bytes per transaction; must equal the spi_master setting (>=1)
//  SpiBaseAddress      0      spi_master BaseAddress; offsets +0 wr byte, +1 rd byte, +2 start, +3 busy
//  StartSettleCycles   4      cycles between start write and first busy poll (>=3)
//  address_width       16     bus address width
//  data_width          8      bus data width (>=8)
// PORTS
//  clk_i          in   1                          system clock
//  reset_ni       in   1                          async reset, active-low
//  req_i          in   NumRequesters              per-client request; hold until done_o
//  tx_data_i      in   NumRequesters x 8*BPT      per-client tx word, MSB byte sent first
//  gnt_o          out  NumRequesters              one-hot grant, high for whole transaction
//  done_o         out  NumRequesters              one-cycle completion pulse to granted client
//  rx_data_o      out  8*BPT                      rx word, valid with done_o, held until next done
//  active_id_o    out  IdWidth                    index of granted client (slave-select mux)
//  busy_o         out  1                          high from grant through done cycle
//  bus_address_o  out  address_width              to spi_master address_i
//  bus_data_o     out  data_width                 to spi_master data_i
//  bus_rd_wr_o    out  1                          to spi_master rd_wr_i (1 = write)
//  bus_data_i     in   data_width                 from spi_master data_o (registered, 1-cycle latency)
// BEHAVIOUR
//  Reset (async, immediate): gnt_o/done_o/busy_o/rx_data_o/active_id_o=0, bus_rd_wr_o=0,
//   bus_address_o=Base+3, bus_data_o=0, rr pointer=last_id=NumRequesters-1, state S_IDLE.
//  Bus idle default: rd_wr=0, addr=Base+3 (side-effect free; keeps rd_wr low so spi_master
//   captures rx on its rx_done pulse). Never present Base+1 with rd_wr=0 except in S_READ.
//  S_IDLE: any req_i -> winner = first set bit searching from last_id+1 with wrap; latch
//   tx_data_i[winner] into shift reg; gnt_o/busy_o/active_id_o registered next cycle -> S_WRITE.
//  S_WRITE: BPT cycles, rd_wr=1, addr=Base+0, data=top byte of shift reg; shift left 8 -> S_START.
//  S_START: 1 cycle, rd_wr=1, addr=Base+2, data=1 -> S_SETTLE.
//  S_SETTLE: StartSettleCycles cycles, bus idle default (covers spi_master start/busy latency).
//  S_POLL: addr=Base+3, rd_wr=0 each cycle; bus_data_i[0]==0 -> S_READ; else stay. No timeout.
//  S_READ: BPT+1 cycles; cycles 0..BPT-1 addr=Base+1 rd_wr=0; capture bus_data_i in cycles
//   1..BPT, shifting into rx reg (first captured = MSB byte); cycle BPT addr back to Base+3.
//  S_DONE: 1 cycle: done_o[id]=1, rx_data_o=rx reg, gnt_o/busy_o drop next cycle, last_id=id -> S_IDLE.
//  Latency req->gnt 1 cycle; total = 1+BPT+1+StartSettleCycles+polls+(BPT+1)+1.
//  Boundaries: req drop mid-transaction ignored, transaction completes and done_o pulses;
//   simultaneous reqs resolved strictly round-robin; req held through done re-arbitrates in the
//   S_IDLE cycle after S_DONE (no starvation); tx_data_i changes after grant ignored;
//   NumRequesters=1 -> always id 0. Reset mid-transaction aborts with no done_o; spi_master must
//   share the system reset (its own sync reset) so no stale start/busy survives.
// STRUCTURE
//  spi_ctrl_pkg: SPI_WR_BYTE_OFS=0, SPI_RD_BYTE_OFS=1, SPI_START_OFS=2, SPI_BUSY_OFS=3;
//   spi_arb_state_t enum {S_IDLE,S_WRITE,S_START,S_SETTLE,S_POLL,S_READ,S_DONE}.
//  Sub-module rr_arbiter (req vector + last_id -> one-hot winner + index, combinational).
//  Byte/settle counters and tx/rx shift regs in this module.
// TESTING (bench: spi_master Base=0, BPT=2, FPGAClk/SPIClk divider 25, miso looped to mosi)
//  req_i=0001, tx0=A55A -> bus writes (0,A5),(0,5A),(2,01); rx_data_o=A55A with done_o=0001 one cycle.
//  req_i=1111 held, distinct tx -> grant order 0,1,2,3,0; each done returns own tx word.
//  Slow SPI clock -> no Base+1 read issued while busy=1; exactly 2 Base+1 read cycles per transaction.
//  reset_ni low in S_POLL -> all outputs at reset values same cycle; after release req1 restarts cleanly.
//  req0 dropped after grant -> transaction completes, done_o[0] pulses, gnt_o then 0.
//  last_id=1, req_i=1001 -> client 3 granted before client 0.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - spi_master register offsets and arbiter state encoding
package spi_ctrl_pkg;

  localparam int SPI_WR_BYTE_OFS = 0;
  localparam int SPI_RD_BYTE_OFS = 1;
  localparam int SPI_START_OFS   = 2;
  localparam int SPI_BUSY_OFS    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_START,
    S_SETTLE,
    S_POLL,
    S_READ,
    S_DONE
  } spi_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_id with wrap
module rr_arbiter #(
  parameter int NumReq  = 4,
  parameter int IdWidth = 2
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] last_id_i,
  output logic [NumReq-1:0]  gnt_o,
  output logic [IdWidth-1:0] id_o,
  output logic               valid_o
);

  localparam logic [IdWidth:0] NumReqW = (IdWidth + 1)'(NumReq);

  // One spare bit so last_id + k never overflows before the wrap subtraction.
  logic [IdWidth:0] cand;

  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = {1'b0, last_id_i} + (IdWidth + 1)'(k);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (!valid_o && req_i[cand[IdWidth-1:0]]) begin
        valid_o = 1'b1;
        id_o    = cand[IdWidth-1:0];
      end
    end
    gnt_o[id_o] = valid_o;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin sharing of one spi_master register port among clients
module spi_txn_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NumRequesters       = 4,
  parameter int BytesPerTransaction = 1,
  parameter int SpiBaseAddress      = 0,
  parameter int StartSettleCycles   = 4,
  parameter int address_width       = 16,
  parameter int data_width          = 8,
  localparam int IdWidth            = (NumRequesters > 1) ? $clog2(NumRequesters) : 1,
  localparam int WordWidth          = 8 * BytesPerTransaction
) (
  input  logic                                     clk_i,
  input  logic                                     reset_ni,
  input  logic [NumRequesters-1:0]                 req_i,
  input  logic [NumRequesters-1:0][WordWidth-1:0]  tx_data_i,
  output logic [NumRequesters-1:0]                 gnt_o,
  output logic [NumRequesters-1:0]                 done_o,
  output logic [WordWidth-1:0]                     rx_data_o,
  output logic [IdWidth-1:0]                       active_id_o,
  output logic                                     busy_o,
  output logic [address_width-1:0]                 bus_address_o,
  output logic [data_width-1:0]                    bus_data_o,
  output logic                                     bus_rd_wr_o,
  input  logic [data_width-1:0]                    bus_data_i
);

  localparam int CntMax = (BytesPerTransaction + 1 > StartSettleCycles) ?
                          BytesPerTransaction + 1 : StartSettleCycles;
  localparam int CntW   = $clog2(CntMax + 1);

  localparam logic [address_width-1:0] AddrWr    = address_width'(SpiBaseAddress + SPI_WR_BYTE_OFS);
  localparam logic [address_width-1:0] AddrRd    = address_width'(SpiBaseAddress + SPI_RD_BYTE_OFS);
  localparam logic [address_width-1:0] AddrStart = address_width'(SpiBaseAddress + SPI_START_OFS);
  localparam logic [address_width-1:0] AddrBusy  = address_width'(SpiBaseAddress + SPI_BUSY_OFS);

  spi_arb_state_t              state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [WordWidth-1:0]        tx_sh_q, tx_sh_d;
  logic [WordWidth-1:0]        rx_sh_q, rx_sh_d;
  logic [WordWidth-1:0]        rx_data_q, rx_data_d;
  logic [NumRequesters-1:0]    gnt_q, gnt_d;
  logic [NumRequesters-1:0]    done_q, done_d;
  logic [IdWidth-1:0]          id_q, id_d;
  logic [IdWidth-1:0]          last_id_q, last_id_d;
  logic                        busy_q, busy_d;

  logic [NumRequesters-1:0]    arb_gnt;
  logic [IdWidth-1:0]          arb_id;
  logic                        arb_valid;
  logic [WordWidth-1:0]        rx_next;

  rr_arbiter #(
    .NumReq  (NumRequesters),
    .IdWidth (IdWidth)
  ) u_rr_arbiter (
    .req_i     (req_i),
    .last_id_i (last_id_q),
    .gnt_o     (arb_gnt),
    .id_o      (arb_id),
    .valid_o   (arb_valid)
  );

  assign rx_next = (rx_sh_q << 8) | WordWidth'(bus_data_i[7:0]);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    rx_data_d     = rx_data_q;
    gnt_d         = gnt_q;
    done_d        = '0;
    id_d          = id_q;
    last_id_d     = last_id_q;
    busy_d        = busy_q;
    // Idle bus parks on the busy register with rd_wr low: harmless to read
    // and lets spi_master capture rx on its own rx_done pulse.
    bus_address_o = AddrBusy;
    bus_data_o    = '0;
    bus_rd_wr_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          id_d    = arb_id;
          busy_d  = 1'b1;
          tx_sh_d = tx_data_i[arb_id];
          cnt_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        bus_rd_wr_o   = 1'b1;
        bus_address_o = AddrWr;
        bus_data_o    = data_width'(tx_sh_q[WordWidth-1 -: 8]);
        tx_sh_d       = tx_sh_q << 8;
        if (cnt_q == CntW'(BytesPerTransaction - 1)) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        bus_rd_wr_o   = 1'b1;
        bus_address_o = AddrStart;
        bus_data_o    = data_width'(1);
        cnt_d         = '0;
        state_d       = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CntW'(StartSettleCycles - 1)) begin
          cnt_d   = '0;
          state_d = S_POLL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_POLL: begin
        if (!bus_data_i[0]) begin
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Read data returns one cycle after the address, so capture lags by one.
        if (cnt_q < CntW'(BytesPerTransaction)) bus_address_o = AddrRd;
        if (cnt_q != '0) rx_sh_d = rx_next;
        if (cnt_q == CntW'(BytesPerTransaction)) begin
          rx_data_d = rx_next;
          done_d    = gnt_q;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        gnt_d     = '0;
        busy_d    = 1'b0;
        last_id_d = id_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      id_q      <= '0;
      last_id_q <= IdWidth'(NumRequesters - 1);
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rx_data_o   = rx_data_q;
  assign active_id_o = id_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - directed bench with a loopback spi_master register model
module tb_spi_txn_arbiter;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [3:0][15:0]  tx_data;
  logic [3:0]        gnt;
  logic [3:0]        done;
  logic [15:0]       rx_data;
  logic [1:0]        active_id;
  logic              busy;
  logic [15:0]       bus_address;
  logic [7:0]        bus_data;
  logic              bus_rd_wr;
  logic [7:0]        m_dout;

  int n_vec  = 0;
  int n_miss = 0;

  spi_txn_arbiter #(
    .NumRequesters       (4),
    .BytesPerTransaction (2),
    .SpiBaseAddress      (0),
    .StartSettleCycles   (4),
    .address_width       (16),
    .data_width          (8)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .req_i         (req),
    .tx_data_i     (tx_data),
    .gnt_o         (gnt),
    .done_o        (done),
    .rx_data_o     (rx_data),
    .active_id_o   (active_id),
    .busy_o        (busy),
    .bus_address_o (bus_address),
    .bus_data_o    (bus_data),
    .bus_rd_wr_o   (bus_rd_wr),
    .bus_data_i    (m_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // spi_master stand-in: two-byte buffers, MISO looped to MOSI, registered read data.
  logic [7:0]  m_tx [2];
  logic [7:0]  m_rx [2];
  logic        m_wr, m_rd, m_busy;
  logic [1:0]  m_pend;
  int          m_cnt;
  int          spi_len;
  int          rd_cycles = 0;
  int          rd_viol   = 0;
  logic [15:0] wlog [$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wr <= 1'b0; m_rd <= 1'b0; m_busy <= 1'b0; m_pend <= 2'd0; m_cnt <= 0; m_dout <= 8'h00;
    end else begin
      if (bus_rd_wr) wlog.push_back({bus_address[7:0], bus_data});
      if (bus_rd_wr && bus_address == 16'd0) begin
        m_tx[m_wr] <= bus_data;
        m_wr       <= ~m_wr;
      end
      if (bus_rd_wr && bus_address == 16'd2 && bus_data[0]) begin
        m_pend <= 2'd2;
      end else if (m_pend != 2'd0) begin
        m_pend <= m_pend - 2'd1;
        if (m_pend == 2'd1) begin
          m_busy <= 1'b1;
          m_cnt  <= spi_len;
        end
      end
      if (m_busy) begin
        if (m_cnt <= 1) begin
          m_busy  <= 1'b0;
          m_rx[0] <= m_tx[0];
          m_rx[1] <= m_tx[1];
          m_wr    <= 1'b0;
          m_rd    <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (!bus_rd_wr && bus_address == 16'd1) begin
        m_dout    <= m_rx[m_rd];
        m_rd      <= ~m_rd;
        rd_cycles = rd_cycles + 1;
        if (m_busy) rd_viol = rd_viol + 1;
      end else if (!bus_rd_wr && bus_address == 16'd3) begin
        m_dout <= {7'b0, m_busy};
      end else begin
        m_dout <= 8'h00;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done != 4'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int w0;
  int r0;

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0;
    tx_data = '0;
    spi_len = 10;
    tick(); tick();

    check("rst_gnt",  32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rx",   32'(rx_data), 32'h0);
    check("rst_id",   32'(active_id), 32'h0);
    check("rst_rdwr", 32'(bus_rd_wr), 32'h0);
    check("rst_addr", 32'(bus_address), 32'h3);
    check("rst_data", 32'(bus_data), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single transaction from client 0.
    tx_data[0] = 16'hA55A;
    w0 = wlog.size();
    r0 = rd_cycles;
    req = 4'b0001;
    tick();
    check("t1_gnt",  32'(gnt), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    wait_done();
    req = 4'b0000;
    check("t1_done",  32'(done), 32'h1);
    check("t1_rx",    32'(rx_data), 32'hA55A);
    check("t1_gnt_done", 32'(gnt), 32'h1);
    check("t1_nwr",   32'(wlog.size() - w0), 32'd3);
    if (wlog.size() - w0 >= 3) begin
      check("t1_wr0", 32'(wlog[w0]),   32'h00A5);
      check("t1_wr1", 32'(wlog[w0+1]), 32'h005A);
      check("t1_wr2", 32'(wlog[w0+2]), 32'h0201);
    end
    check("t1_rdcyc", 32'(rd_cycles - r0), 32'd2);
    tick();
    check("t1_done_clr", 32'(done), 32'h0);
    check("t1_gnt_clr",  32'(gnt), 32'h0);
    check("t1_busy_clr", 32'(busy), 32'h0);
    check("t1_rx_hold",  32'(rx_data), 32'hA55A);

    // All four held, slow SPI: strict rotation from reset pointer.
    pulse_reset();
    spi_len    = 60;
    tx_data[0] = 16'h1111;
    tx_data[1] = 16'h2222;
    tx_data[2] = 16'h3333;
    tx_data[3] = 16'h4444;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      r0 = rd_cycles;
      wait_done();
      check("rr_id",    32'(active_id), 32'(k % 4));
      check("rr_done",  32'(done), 32'(1 << (k % 4)));
      check("rr_rx",    32'(rx_data), 32'(tx_data[k % 4]));
      check("rr_rdcyc", 32'(rd_cycles - r0), 32'd2);
    end
    req = 4'b0000;
    tick(); tick();

    // Reset while polling busy, then client 1 restarts cleanly.
    tx_data[1] = 16'hC3E1;
    req = 4'b0010;
    tick();
    check("t3_gnt", 32'(gnt), 32'h2);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("t3_rst_gnt",  32'(gnt), 32'h0);
    check("t3_rst_busy", 32'(busy), 32'h0);
    check("t3_rst_addr", 32'(bus_address), 32'h3);
    check("t3_rst_rdwr", 32'(bus_rd_wr), 32'h0);
    check("t3_rst_id",   32'(active_id), 32'h0);
    check("t3_rst_rx",   32'(rx_data), 32'h0);
    tick();
    rst_n = 1'b1;
    wait_done();
    req = 4'b0000;
    check("t3_done", 32'(done), 32'h2);
    check("t3_rx",   32'(rx_data), 32'hC3E1);

    // last_id is 1: client 3 wins over client 0.
    tx_data[3] = 16'hBEEF;
    tx_data[0] = 16'h0F0F;
    req = 4'b1001;
    tick(); tick(); tick();
    check("t4_gnt", 32'(gnt), 32'h8);
    check("t4_id",  32'(active_id), 32'h3);
    wait_done();
    req = 4'b0001;
    check("t4_done", 32'(done), 32'h8);
    check("t4_rx",   32'(rx_data), 32'hBEEF);
    tick();
    check("t4_idle_gnt", 32'(gnt), 32'h0);
    tick();
    check("t4_next_gnt", 32'(gnt), 32'h1);

    // Client 0 drops req and changes tx after grant; both ignored.
    req        = 4'b0000;
    tx_data[0] = 16'h5555;
    wait_done();
    check("t5_done", 32'(done), 32'h1);
    check("t5_rx",   32'(rx_data), 32'h0F0F);
    tick();
    check("t5_gnt_clr",  32'(gnt), 32'h0);
    check("t5_busy_clr", 32'(busy), 32'h0);
    check("t5_done_clr", 32'(done), 32'h0);

    check("rd_while_busy", 32'(rd_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
